// File: rtl/mc_cfg_pkg.sv
// Shared constants for the macrocell fuse loader: frame geometry, field offsets,
// flag fuse indices and the loader state encoding.
package mc_cfg_pkg;

    localparam int PT_BITS   = 480;
    localparam int FLAG_BITS = 16;
    localparam int CFG_BITS  = 3 + 2 + PT_BITS + FLAG_BITS;
    localparam int CNT_W     = $clog2(CFG_BITS + 1);

    localparam int OE_OFS   = 0;
    localparam int GCLK_OFS = 3;
    localparam int PT_OFS   = 5;
    localparam int FLAG_OFS = 485;

    localparam int FL_PT1      = 0;
    localparam int FL_PT2      = 1;
    localparam int FL_PT3      = 2;
    localparam int FL_PT4      = 3;
    localparam int FL_PT5      = 4;
    localparam int FL_GCLR     = 5;
    localparam int FL_PT4_FUNC = 6;
    localparam int FL_PT5_FUNC = 7;
    localparam int FL_XOR_A    = 8;
    localparam int FL_XOR_B    = 9;
    localparam int FL_XOR_INV  = 10;
    localparam int FL_D        = 11;
    localparam int FL_DFAST    = 12;
    localparam int FL_STORAGE  = 13;
    localparam int FL_FB       = 14;
    localparam int FL_O        = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } ldr_state_t;

    // True when the counter points at the trailing parity bit of the frame.
    function automatic logic is_parity_pos(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(CFG_BITS);
    endfunction

endpackage

// File: rtl/mc_config_loader_if.sv
// Serial load handshake and status bundle between a frame source and the loader.
interface mc_config_loader_if;
    logic load_start;
    logic sdi;
    logic sdi_valid;
    logic sdi_ready;
    logic busy;
    logic cfg_valid;
    logic cfg_err;

    modport master (
        output load_start, sdi, sdi_valid,
        input  sdi_ready, busy, cfg_valid, cfg_err
    );

    modport slave (
        input  load_start, sdi, sdi_valid,
        output sdi_ready, busy, cfg_valid, cfg_err
    );
endinterface

// File: rtl/mc_cfg_unpack.sv
// Combinational split of the flat active config vector into named macrocell fuses.
module mc_cfg_unpack
    import mc_cfg_pkg::*;
(
    input  logic [CFG_BITS-1:0] i_active,
    output logic [2:0]          oe_mux,
    output logic [1:0]          gclk_mux,
    output logic [PT_BITS-1:0]  ptgroupbitmap_mux,
    output logic                pt1_mux,
    output logic                pt2_mux,
    output logic                pt3_mux,
    output logic                pt4_mux,
    output logic                pt5_mux,
    output logic                gclr_mux,
    output logic                pt4_func_mux,
    output logic                pt5_func_mux,
    output logic                xor_a_mux,
    output logic                xor_b_mux,
    output logic                xor_inv_mux,
    output logic                d_mux,
    output logic                dfast_mux,
    output logic                storage_mux,
    output logic                fb_mux,
    output logic                o_mux
);
    logic [FLAG_BITS-1:0] w_flags;

    assign oe_mux            = i_active[OE_OFS +: 3];
    assign gclk_mux          = i_active[GCLK_OFS +: 2];
    assign ptgroupbitmap_mux = i_active[PT_OFS +: PT_BITS];
    assign w_flags           = i_active[FLAG_OFS +: FLAG_BITS];

    assign pt1_mux      = w_flags[FL_PT1];
    assign pt2_mux      = w_flags[FL_PT2];
    assign pt3_mux      = w_flags[FL_PT3];
    assign pt4_mux      = w_flags[FL_PT4];
    assign pt5_mux      = w_flags[FL_PT5];
    assign gclr_mux     = w_flags[FL_GCLR];
    assign pt4_func_mux = w_flags[FL_PT4_FUNC];
    assign pt5_func_mux = w_flags[FL_PT5_FUNC];
    assign xor_a_mux    = w_flags[FL_XOR_A];
    assign xor_b_mux    = w_flags[FL_XOR_B];
    assign xor_inv_mux  = w_flags[FL_XOR_INV];
    assign d_mux        = w_flags[FL_D];
    assign dfast_mux    = w_flags[FL_DFAST];
    assign storage_mux  = w_flags[FL_STORAGE];
    assign fb_mux       = w_flags[FL_FB];
    assign o_mux        = w_flags[FL_O];
endmodule

// File: rtl/mc_config_loader.sv
// Serial fuse loader: shifts a framed bitstream into a shadow register, checks odd
// parity, and commits the frame atomically to the active macrocell config.
module mc_config_loader
    import mc_cfg_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    mc_config_loader_if.slave   bus,
    output logic [2:0]          oe_mux,
    output logic [1:0]          gclk_mux,
    output logic [PT_BITS-1:0]  ptgroupbitmap_mux,
    output logic                pt1_mux,
    output logic                pt2_mux,
    output logic                pt3_mux,
    output logic                pt4_mux,
    output logic                pt5_mux,
    output logic                gclr_mux,
    output logic                pt4_func_mux,
    output logic                pt5_func_mux,
    output logic                xor_a_mux,
    output logic                xor_b_mux,
    output logic                xor_inv_mux,
    output logic                d_mux,
    output logic                dfast_mux,
    output logic                storage_mux,
    output logic                fb_mux,
    output logic                o_mux
);
    ldr_state_t          r_state;
    ldr_state_t          w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_parity;
    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic                r_cfg_valid;
    logic                r_cfg_err;
    logic                w_xfer;
    logic                w_commit;
    logic                w_fail;

    // load_start has priority over a coincident transfer, so the bit is dropped.
    assign w_xfer = (r_state == SHIFT) && bus.sdi_valid && !bus.load_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_fail       = 1'b0;
        if (bus.load_start) begin
            w_state_next = SHIFT;
        end else begin
            case (r_state)
                IDLE:  w_state_next = IDLE;
                SHIFT: if (w_xfer && is_parity_pos(r_cnt)) w_state_next = CHECK;
                CHECK: begin
                    w_state_next = IDLE;
                    w_commit     = r_parity;
                    w_fail       = !r_parity;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_parity    <= 1'b0;
            r_shadow    <= '0;
            r_active    <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            if (bus.load_start) begin
                r_cnt     <= '0;
                r_parity  <= 1'b0;
                r_cfg_err <= 1'b0;
            end else if (w_xfer) begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_parity <= r_parity ^ bus.sdi;
            end
            // The parity bit only feeds the running XOR; it has no shadow slot.
            if (w_xfer && !is_parity_pos(r_cnt)) r_shadow[r_cnt] <= bus.sdi;
            if (w_commit) begin
                r_active    <= r_shadow;
                r_cfg_valid <= 1'b1;
            end
            if (w_fail) r_cfg_err <= 1'b1;
        end
    end

    assign bus.sdi_ready = (r_state == SHIFT);
    assign bus.busy      = (r_state != IDLE);
    assign bus.cfg_valid = r_cfg_valid;
    assign bus.cfg_err   = r_cfg_err;

    mc_cfg_unpack u_unpack (
        .i_active          (r_active),
        .oe_mux            (oe_mux),
        .gclk_mux          (gclk_mux),
        .ptgroupbitmap_mux (ptgroupbitmap_mux),
        .pt1_mux           (pt1_mux),
        .pt2_mux           (pt2_mux),
        .pt3_mux           (pt3_mux),
        .pt4_mux           (pt4_mux),
        .pt5_mux           (pt5_mux),
        .gclr_mux          (gclr_mux),
        .pt4_func_mux      (pt4_func_mux),
        .pt5_func_mux      (pt5_func_mux),
        .xor_a_mux         (xor_a_mux),
        .xor_b_mux         (xor_b_mux),
        .xor_inv_mux       (xor_inv_mux),
        .d_mux             (d_mux),
        .dfast_mux         (dfast_mux),
        .storage_mux       (storage_mux),
        .fb_mux            (fb_mux),
        .o_mux             (o_mux)
    );
endmodule

// File: tb/tb_mc_config_loader.sv
// Randomized bench for mc_config_loader: a driver sends frames and queues the expected
// config; a monitor checks every frame completion against a simple frame-level model.
module tb_mc_config_loader;
    import mc_cfg_pkg::*;

    typedef struct packed {
        logic [CFG_BITS-1:0] cfg;
        logic                valid;
        logic                err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_config_loader_if bus ();

    logic [2:0]         oe_mux;
    logic [1:0]         gclk_mux;
    logic [PT_BITS-1:0] ptgroupbitmap_mux;
    logic pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux, gclr_mux, pt4_func_mux, pt5_func_mux;
    logic xor_a_mux, xor_b_mux, xor_inv_mux, d_mux, dfast_mux, storage_mux, fb_mux, o_mux;

    mc_config_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .oe_mux            (oe_mux),
        .gclk_mux          (gclk_mux),
        .ptgroupbitmap_mux (ptgroupbitmap_mux),
        .pt1_mux           (pt1_mux),
        .pt2_mux           (pt2_mux),
        .pt3_mux           (pt3_mux),
        .pt4_mux           (pt4_mux),
        .pt5_mux           (pt5_mux),
        .gclr_mux          (gclr_mux),
        .pt4_func_mux      (pt4_func_mux),
        .pt5_func_mux      (pt5_func_mux),
        .xor_a_mux         (xor_a_mux),
        .xor_b_mux         (xor_b_mux),
        .xor_inv_mux       (xor_inv_mux),
        .d_mux             (d_mux),
        .dfast_mux         (dfast_mux),
        .storage_mux       (storage_mux),
        .fb_mux            (fb_mux),
        .o_mux             (o_mux)
    );

    // Observed config reassembled in frame order (bit 0 = oe_mux[0], bit 500 = o_mux).
    logic [CFG_BITS-1:0] obs;
    assign obs = {o_mux, fb_mux, storage_mux, dfast_mux, d_mux, xor_inv_mux, xor_b_mux,
                  xor_a_mux, pt5_func_mux, pt4_func_mux, gclr_mux, pt5_mux, pt4_mux,
                  pt3_mux, pt2_mux, pt1_mux, ptgroupbitmap_mux, gclk_mux, oe_mux};

    int n_checks   = 0;
    int n_pass     = 0;
    int ready_drops = 0;
    exp_t exp_q[$];

    logic [CFG_BITS-1:0] m_cfg;
    logic                m_valid;
    logic                m_err;

    task automatic check(input string name, input logic [CFG_BITS-1:0] act,
                         input logic [CFG_BITS-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Monitor: each busy 1->0 transition marks a completed frame check.
    logic prev_busy = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !bus.busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame_end: busy fell with no frame outstanding");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cfg", obs, mon_e.cfg);
                    check("cfg_valid", CFG_BITS'(bus.cfg_valid), CFG_BITS'(mon_e.valid));
                    check("cfg_err", CFG_BITS'(bus.cfg_err), CFG_BITS'(mon_e.err));
                    check("ready_after_check", CFG_BITS'(bus.sdi_ready), '0);
                    $display("frame done: valid=%0b err=%0b cfg[31:0]=%h",
                             bus.cfg_valid, bus.cfg_err, obs[31:0]);
                end
            end
            prev_busy = bus.busy;
        end
    end

    function automatic logic [CFG_BITS-1:0] rand_cfg();
        logic [CFG_BITS-1:0] v;
        for (int k = 0; k < CFG_BITS; k++) v[k] = 1'($urandom_range(1, 0));
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.sdi_valid  = 1'b0;
        bus.load_start = 1'b1;
        m_err          = 1'b0;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        if (!bus.sdi_ready) ready_drops++;
        bus.sdi_valid = 1'b1;
        bus.sdi       = b;
        @(negedge clk);
    endtask

    // Sends a whole frame; restart_at >= 0 pulses load_start alongside that bit.
    task automatic send_frame(input logic [CFG_BITS-1:0] data, input bit good,
                              input int max_stall, input int restart_at);
        logic [CFG_BITS:0] frame;
        int  i;
        bit  restarted;
        frame     = {(good ? ~(^data) : (^data)), data};
        restarted = 1'b0;
        pulse_start();
        i = 0;
        while (i <= CFG_BITS) begin
            if (max_stall > 0) begin
                bus.sdi_valid = 1'b0;
                repeat ($urandom_range(max_stall, 0)) @(negedge clk);
            end
            if (i == restart_at && !restarted) begin
                restarted      = 1'b1;
                bus.load_start = 1'b1;
                m_err          = 1'b0;
                drive_bit(frame[i]);
                bus.load_start = 1'b0;
                i = 0;
            end else begin
                drive_bit(frame[i]);
                i++;
            end
        end
        bus.sdi_valid = 1'b0;
        if (good) begin
            m_cfg   = data;
            m_valid = 1'b1;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        exp_q.push_back('{cfg: m_cfg, valid: m_valid, err: m_err});
    endtask

    task automatic send_partial(input logic [CFG_BITS-1:0] data, input int nbits);
        pulse_start();
        for (int k = 0; k < nbits; k++) drive_bit(data[k]);
        bus.sdi_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            n_checks++;
            $display("FAIL idle_timeout: busy=1 after 20 cycles, required 0");
        end
        @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cfg"}, obs, m_cfg);
        check({tag, "_valid"}, CFG_BITS'(bus.cfg_valid), CFG_BITS'(m_valid));
        check({tag, "_err"}, CFG_BITS'(bus.cfg_err), CFG_BITS'(m_err));
    endtask

    initial begin
        logic [CFG_BITS-1:0] d;
        bus.load_start = 1'b0;
        bus.sdi        = 1'b0;
        bus.sdi_valid  = 1'b0;
        m_cfg   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_status("reset");
        check("reset_busy", CFG_BITS'(bus.busy), '0);
        check("reset_ready", CFG_BITS'(bus.sdi_ready), '0);

        // All ones, then single-bit frames at the first PT fuse and the last flag.
        d = '1;
        send_frame(d, 1'b1, 0, -1);
        wait_idle();
        d = '0; d[5] = 1'b1;
        send_frame(d, 1'b1, 0, -1);
        wait_idle();
        check("pt0_only", CFG_BITS'(ptgroupbitmap_mux[0]), CFG_BITS'(1));
        d = '0; d[500] = 1'b1;
        send_frame(d, 1'b1, 0, -1);
        wait_idle();
        check("o_mux_only", CFG_BITS'(o_mux), CFG_BITS'(1));

        // Good frame A, then frame with bad parity: A must stay live.
        send_frame(rand_cfg(), 1'b1, 0, -1);
        wait_idle();
        send_frame(rand_cfg(), 1'b0, 0, -1);
        wait_idle();

        // Stalled delivery.
        send_frame(rand_cfg(), 1'b1, 7, -1);
        wait_idle();

        // Abort after 200 bits: old config stays live until the new one commits.
        send_partial(rand_cfg(), 200);
        @(negedge clk);
        check_status("abort_live");
        send_frame(rand_cfg(), 1'b1, 0, -1);
        wait_idle();

        // load_start coincident with a transfer drops that bit and restarts.
        send_frame(rand_cfg(), 1'b1, 0, 50);
        wait_idle();

        // Asynchronous reset mid-frame, checked before the next rising edge.
        send_partial(rand_cfg(), 300);
        #2 rst_n = 1'b0;
        #1;
        m_cfg   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        check_status("async_rst");
        check("async_rst_busy", CFG_BITS'(bus.busy), '0);
        check("async_rst_ready", CFG_BITS'(bus.sdi_ready), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(rand_cfg(), 1'b1, 0, -1);
        wait_idle();

        // A few random frames with random parity quality and light stalls.
        for (int r = 0; r < 3; r++) begin
            send_frame(rand_cfg(), 1'($urandom_range(3, 0) != 0), 3, -1);
            wait_idle();
        end

        check("sdi_ready_drops", CFG_BITS'(ready_drops), '0);
        check("pending_frames", CFG_BITS'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end
endmodule
